// File: rtl/dp_sec3_accum.sv
// dp_sec3_accum: third datapath slice. A 16-bit add/subtract unit picks its
// operands with an A/B select front end and loads the result into the
// accumulator and/or the M register.
// Optional build macro: DP_SEC3_SATURATE_EN makes the result saturate
// (unsigned) instead of wrapping modulo 2^WIDTH.
module dp_sec3_accum #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] sub,
  input  logic [WIDTH-1:0] two,
  input  logic [WIDTH-1:0] one,
  input  logic             CTRL3,
  input  logic             CTRL4,
  input  logic             CTRL5,
  input  logic             CTRL8,
  input  logic             CTRL9,
  output logic [WIDTH-1:0] a1out,
  output logic [WIDTH-1:0] mout
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] m_q,   m_d;
  logic [WIDTH-1:0] opa, opb, res;

  // ALU operation: op=0 adds, op=1 subtracts. Unsigned throughout.
  function automatic logic [WIDTH-1:0] alu_f(
    input logic             op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
`ifdef DP_SEC3_SATURATE_EN
    logic [WIDTH:0] ext;
    // The extra MSB is the carry on add and the borrow on subtract.
    ext = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    if (ext[WIDTH]) begin
      alu_f = op ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      alu_f = ext[WIDTH-1:0];
    end
`else
    alu_f = op ? (a - b) : (a + b);
`endif
  endfunction

  // Operand select, ALU and next-state selection for both result registers.
  always_comb begin
    opa   = CTRL4 ? acc_q : sub;
    opb   = CTRL3 ? two : one;
    res   = alu_f(CTRL5, opa, opb);
    acc_d = CTRL8 ? res : acc_q;
    m_d   = CTRL9 ? res : m_q;
  end

  // ---- register stage: result registers, cleared asynchronously ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
      m_q   <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
    end
  end

  assign a1out = acc_q;
  assign mout  = m_q;

endmodule

// File: tb/tb_dp_sec3_accum.sv
// Testbench for dp_sec3_accum: vector table plus hand-written reset
// sequences and a randomized run against a behavioural model.
module tb_dp_sec3_accum;

`ifdef DP_SEC3_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] sub = '0, two = 16'd2, one = 16'd1;
  logic        CTRL3 = 0, CTRL4 = 0, CTRL5 = 0, CTRL8 = 0, CTRL9 = 0;
  logic [15:0] a1out, mout;

  dp_sec3_accum #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .sub(sub), .two(two), .one(one),
    .CTRL3(CTRL3), .CTRL4(CTRL4), .CTRL5(CTRL5), .CTRL8(CTRL8), .CTRL9(CTRL9),
    .a1out(a1out), .mout(mout)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] sub, two, one;
    logic        c3, c4, c5, c8, c9;
    logic [15:0] ea, em;
  } vec_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] m;
  } exp_t;

  vec_t  tbl[13];
  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] mdl_a, mdl_m;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: wide signed integer math, then clamp or wrap.
  function automatic logic [15:0] ref_alu(input logic op, input logic [15:0] a,
                                          input logic [15:0] b);
    int r;
    r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    if (SAT) begin
      if (r < 0) r = 0;
      if (r > 65535) r = 65535;
    end
    return r[15:0];
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic apply(input string name, input vec_t v);
    exp_t e, got;
    sub = v.sub; two = v.two; one = v.one;
    CTRL3 = v.c3; CTRL4 = v.c4; CTRL5 = v.c5; CTRL8 = v.c8; CTRL9 = v.c9;
    e.a = v.ea; e.m = v.em;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sbq.pop_front();
      chk({name, ".a1out"}, a1out, got.a);
      chk({name, ".mout"},  mout,  got.m);
    end
    mdl_a = v.ea;
    mdl_m = v.em;
  endtask

  initial begin
    vec_t v;
    // {sub, two, one, c3, c4, c5, c8, c9, exp a1out, exp mout}
    tbl[0]  = '{16'd6,     16'd2,    16'd1, 0,0,0,1,0, 16'd7, 16'd0};          // seed
    tbl[1]  = '{16'd6,     16'd2,    16'd1, 1,1,1,1,0, 16'd5, 16'd0};          // fb -2
    tbl[2]  = '{16'd6,     16'd2,    16'd1, 1,1,1,1,0, 16'd3, 16'd0};          // fb -2
    tbl[3]  = '{16'd6,     16'd2,    16'd1, 0,1,0,0,1, 16'd3, 16'd4};          // M only
    tbl[4]  = '{16'd6,     16'd2,    16'd1, 0,1,0,1,1, 16'd4, 16'd4};          // both
    tbl[5]  = '{16'd1,     16'd2,    16'd1, 0,0,1,1,0, 16'd0, 16'd4};          // acc=0
    tbl[6]  = '{16'd1,     16'd2,    16'd1, 0,1,1,1,0, SAT ? 16'h0000 : 16'hFFFF, 16'd4};
    tbl[7]  = '{16'hFFFE,  16'd2,    16'd1, 0,0,0,1,0, 16'hFFFF, 16'd4};
    tbl[8]  = '{16'hFFFE,  16'd2,    16'd1, 0,1,0,1,1, SAT ? 16'hFFFF : 16'h0000,
                                                       SAT ? 16'hFFFF : 16'h0000};
    tbl[9]  = '{16'h1234,  16'h0010, 16'd1, 1,0,0,0,0, SAT ? 16'hFFFF : 16'h0000,
                                                       SAT ? 16'hFFFF : 16'h0000}; // hold
    tbl[10] = '{16'h1234,  16'h0010, 16'd1, 1,0,0,0,1, SAT ? 16'hFFFF : 16'h0000, 16'h1244};
    tbl[11] = '{16'h8000,  16'h0010, 16'd1, 1,0,1,1,0, 16'h7FF0, 16'h1244};
    tbl[12] = '{16'h0001,  16'h0010, 16'd1, 1,0,1,1,1, SAT ? 16'h0000 : 16'hFFF1,
                                                       SAT ? 16'h0000 : 16'hFFF1};

    // Reset asserted between edges with arbitrary controls: clears at once.
    #2;
    sub = 16'hABCD; CTRL3 = 1; CTRL4 = 1; CTRL5 = 1; CTRL8 = 1; CTRL9 = 1;
    RST = 1'b1;
    #1;
    chk("reset_async.a1out", a1out, 16'd0);
    chk("reset_async.mout",  mout,  16'd0);
    // Edges while held in reset must not load.
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_hold.a1out", a1out, 16'd0);
    chk("reset_hold.mout",  mout,  16'd0);
    RST = 1'b0;

    for (int i = 0; i < 13; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // No combinational path: changing inputs between edges leaves outputs.
    sub = 16'h5555; CTRL4 = 0; CTRL8 = 1; CTRL9 = 1;
    #2;
    chk("no_comb.a1out", a1out, mdl_a);
    chk("no_comb.mout",  mout,  mdl_m);

    // Reset mid-run: load acc=5, then assert reset away from any edge.
    v = '{16'd4, 16'd2, 16'd1, 0,0,0,1,1, 16'd5, 16'd5};
    apply("pre_rst", v);
    #3;
    RST = 1'b1;
    #1;
    chk("rst_mid.a1out", a1out, 16'd0);
    chk("rst_mid.mout",  mout,  16'd0);
    #1;
    RST = 1'b0;
    v = '{16'd6, 16'd2, 16'd1, 0,0,0,1,0, 16'd7, 16'd0};
    apply("post_rst", v);

    // Randomized run against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b, r;
      v.sub = (i % 4 == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      v.two = (i % 3 == 0) ? 16'd2 : 16'($urandom);
      v.one = (i % 5 == 0) ? 16'd1 : 16'($urandom);
      v.c3 = 1'($urandom); v.c4 = 1'($urandom); v.c5 = 1'($urandom);
      v.c8 = 1'($urandom); v.c9 = 1'($urandom);
      a = v.c4 ? mdl_a : v.sub;
      b = v.c3 ? v.two : v.one;
      r = ref_alu(v.c5, a, b);
      v.ea = v.c8 ? r : mdl_a;
      v.em = v.c9 ? r : mdl_m;
      apply($sformatf("rnd%0d", i), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
